// File: rtl/fixed_point_signed_divider.sv
// Sequential signed fixed-point divider. It uses restoring long division on operand
// magnitudes and produces one quotient bit per clock. All three values use the same
// two's-complement Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS format.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        asynchronous active-high reset
//   i_start        request; operands are sampled when high while idle
//   i_data         signed dividend
//   i_divisor      signed divisor
//   o_data         signed quotient, registered, held until the next result
//   o_valid        one-cycle pulse when o_data updates
//   o_busy         high while a division is in progress
//   o_overflow     result was saturated (updates with o_valid)
//   o_div_by_zero  divisor was zero (updates with o_valid)
module fixed_point_signed_divider #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FRAC_BITS  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic                  o_div_by_zero
);

  localparam int unsigned NumW = DATA_WIDTH + FRAC_BITS;
  localparam int unsigned CntW = (NumW > 1) ? $clog2(NumW) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(NumW - 1);

  // Largest magnitudes that still fit the signed result.
  localparam logic [NumW-1:0] MaxPosMag = {{(FRAC_BITS + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [NumW-1:0] MaxNegMag = {{FRAC_BITS{1'b0}}, 1'b1, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SatPos = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SatNeg = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  dvd_neg_q, dvd_neg_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [NumW-1:0]       num_q, num_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [NumW-1:0]       quo_q, quo_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  dbz_q, dbz_d;

  // Magnitudes. The most negative input maps to 2^(DATA_WIDTH-1) as an unsigned value.
  logic [DATA_WIDTH-1:0] abs_data, abs_div;
  assign abs_data = i_data[DATA_WIDTH-1] ? (~i_data + DATA_WIDTH'(1)) : i_data;
  assign abs_div  = i_divisor[DATA_WIDTH-1] ? (~i_divisor + DATA_WIDTH'(1)) : i_divisor;

  // One restoring step. The extra top bit keeps the compare exact.
  logic [DATA_WIDTH+1:0] rem_shift, rem_sub;
  assign rem_shift = {rem_q, num_q[NumW-1]};
  assign rem_sub   = rem_shift - {2'b00, b_q};

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    dvd_neg_d = dvd_neg_q;
    zero_d    = zero_q;
    b_d       = b_q;
    num_d     = num_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          sign_d    = i_data[DATA_WIDTH-1] ^ i_divisor[DATA_WIDTH-1];
          dvd_neg_d = i_data[DATA_WIDTH-1];
          zero_d    = (i_divisor == '0);
          b_d       = abs_div;
          num_d     = {abs_data, {FRAC_BITS{1'b0}}};
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = '0;
          state_d   = StCalc;
        end
      end

      StCalc: begin
        num_d = {num_q[NumW-2:0], 1'b0};
        // With b = 0 every step subtracts nothing; DONE overrides the result anyway.
        if (rem_shift >= {2'b00, b_q}) begin
          rem_d = rem_sub[DATA_WIDTH:0];
          quo_d = {quo_q[NumW-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[DATA_WIDTH:0];
          quo_d = {quo_q[NumW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) begin
          state_d = StDone;
        end
      end

      StDone: begin
        valid_d = 1'b1;
        if (zero_q) begin
          data_d = dvd_neg_q ? SatNeg : SatPos;
          ovf_d  = 1'b0;
          dbz_d  = 1'b1;
        end else if (!sign_q) begin
          dbz_d = 1'b0;
          if (quo_q > MaxPosMag) begin
            data_d = SatPos;
            ovf_d  = 1'b1;
          end else begin
            data_d = quo_q[DATA_WIDTH-1:0];
            ovf_d  = 1'b0;
          end
        end else begin
          dbz_d = 1'b0;
          if (quo_q > MaxNegMag) begin
            data_d = SatNeg;
            ovf_d  = 1'b1;
          end else begin
            // Negating zero stays zero, so no negative-zero case exists.
            data_d = ~quo_q[DATA_WIDTH-1:0] + DATA_WIDTH'(1);
            ovf_d  = 1'b0;
          end
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      sign_q    <= 1'b0;
      dvd_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      b_q       <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      dvd_neg_q <= dvd_neg_d;
      zero_q    <= zero_d;
      b_q       <= b_d;
      num_q     <= num_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_busy        = (state_q != StIdle);
  assign o_overflow    = ovf_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_point_signed_divider.sv
// Directed and random checks for fixed_point_signed_divider at the default Q4.4 format.
module tb_fixed_point_signed_divider;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_data;
  logic [7:0] i_divisor;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_overflow;
  logic       o_div_by_zero;

  int errors = 0;
  int checks = 0;

  fixed_point_signed_divider #(
    .DATA_WIDTH(8),
    .FRAC_BITS (4)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_data       (i_data),
    .i_divisor    (i_divisor),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_div_by_zero(o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Truncating, saturating reference for Q4.4.
  function automatic void model(input logic [7:0] d, input logic [7:0] v,
                                output logic [7:0] q, output logic ovf, output logic dbz);
    int a, b, mq;
    logic neg;
    a   = d[7] ? 256 - int'(d) : int'(d);
    b   = v[7] ? 256 - int'(v) : int'(v);
    neg = d[7] ^ v[7];
    ovf = 1'b0;
    dbz = 1'b0;
    if (b == 0) begin
      dbz = 1'b1;
      q   = d[7] ? 8'h80 : 8'h7F;
    end else begin
      mq = (a * 16) / b;
      if (!neg) begin
        if (mq > 127) begin q = 8'h7F; ovf = 1'b1; end
        else q = 8'(mq);
      end else begin
        if (mq > 128) begin q = 8'h80; ovf = 1'b1; end
        else q = 8'(256 - mq);
      end
    end
  endfunction

  // Called at one time unit after a rising edge; returns there too.
  task automatic start_op(input logic [7:0] d, input logic [7:0] v);
    i_start   = 1'b1;
    i_data    = d;
    i_divisor = v;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  // Edges counted after the start edge until o_valid is seen; -1 if it never comes.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [7:0] d, input logic [7:0] v,
                         input logic [7:0] eq, input logic eo, input logic ez);
    int lat;
    start_op(d, v);
    check_eq({tag, " busy"}, 32'(o_busy), 32'd1);
    wait_valid(lat);
    check_eq({tag, " latency"}, 32'(lat), 32'd13);
    check_eq({tag, " data"}, 32'(o_data), 32'(eq));
    check_eq({tag, " overflow"}, 32'(o_overflow), 32'(eo));
    check_eq({tag, " div_by_zero"}, 32'(o_div_by_zero), 32'(ez));
    check_eq({tag, " busy_done"}, 32'(o_busy), 32'd0);
    @(posedge i_clk);
    #1;
    check_eq({tag, " single_pulse"}, 32'(o_valid), 32'd0);
    check_eq({tag, " data_held"}, 32'(o_data), 32'(eq));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic       seen;
    logic [7:0] d, v, eq;
    logic       eo, ez;

    i_reset   = 1'b1;
    i_start   = 1'b0;
    i_data    = '0;
    i_divisor = '0;
    #12;
    check_eq("reset data", 32'(o_data), 32'd0);
    check_eq("reset valid", 32'(o_valid), 32'd0);
    check_eq("reset busy", 32'(o_busy), 32'd0);
    check_eq("reset overflow", 32'(o_overflow), 32'd0);
    check_eq("reset dbz", 32'(o_div_by_zero), 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // Basic signs, truncation, saturation and division by zero.
    run_vec("pos_pos", 8'h30, 8'h20, 8'h18, 1'b0, 1'b0);
    run_vec("neg_pos", 8'hD0, 8'h20, 8'hE8, 1'b0, 1'b0);
    run_vec("neg_neg", 8'hD0, 8'hE0, 8'h18, 1'b0, 1'b0);
    run_vec("trunc_pos", 8'h10, 8'h30, 8'h05, 1'b0, 1'b0);
    run_vec("trunc_neg", 8'hF0, 8'h30, 8'hFB, 1'b0, 1'b0);
    run_vec("sat_pos", 8'h70, 8'h01, 8'h7F, 1'b1, 1'b0);
    run_vec("sat_minneg", 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b0);
    run_vec("exact_minneg", 8'h80, 8'h10, 8'h80, 1'b0, 1'b0);
    run_vec("zero_dvd", 8'h00, 8'hD0, 8'h00, 1'b0, 1'b0);
    run_vec("dbz_pos", 8'h30, 8'h00, 8'h7F, 1'b0, 1'b1);
    run_vec("dbz_neg", 8'hD0, 8'h00, 8'h80, 1'b0, 1'b1);

    // A second start while busy is ignored, and operand changes have no effect.
    start_op(8'h30, 8'h20);
    repeat (3) begin
      @(posedge i_clk);
      #1;
    end
    i_start   = 1'b1;
    i_data    = 8'h70;
    i_divisor = 8'h01;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_valid(lat);
    check_eq("ignore latency", 32'(lat), 32'd9);
    check_eq("ignore data", 32'(o_data), 32'h18);
    check_eq("ignore overflow", 32'(o_overflow), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) seen = 1'b1;
    end
    check_eq("ignore no_second_result", 32'(seen), 32'd0);

    // A back-to-back start in the o_valid cycle is accepted.
    start_op(8'h10, 8'h30);
    wait_valid(lat);
    check_eq("b2b first latency", 32'(lat), 32'd13);
    check_eq("b2b first data", 32'(o_data), 32'h05);
    start_op(8'hF0, 8'h30);
    check_eq("b2b second busy", 32'(o_busy), 32'd1);
    wait_valid(lat);
    check_eq("b2b second latency", 32'(lat), 32'd13);
    check_eq("b2b second data", 32'(o_data), 32'hFB);

    // Asynchronous reset in the middle of a calculation.
    start_op(8'hD0, 8'h00);
    repeat (5) begin
      @(posedge i_clk);
      #1;
    end
    check_eq("midreset busy_before", 32'(o_busy), 32'd1);
    #3;
    i_reset = 1'b1;
    #1;
    check_eq("midreset data", 32'(o_data), 32'd0);
    check_eq("midreset busy", 32'(o_busy), 32'd0);
    check_eq("midreset valid", 32'(o_valid), 32'd0);
    check_eq("midreset overflow", 32'(o_overflow), 32'd0);
    check_eq("midreset dbz", 32'(o_div_by_zero), 32'd0);
    #2;
    i_reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) seen = 1'b1;
    end
    check_eq("midreset no_valid", 32'(seen), 32'd0);
    run_vec("after_reset", 8'hD0, 8'h00, 8'h80, 1'b0, 1'b1);

    // Random signed sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom_range(0, 255));
      v = 8'($urandom_range(0, 255));
      if (i % 50 == 7) v = 8'h00;
      model(d, v, eq, eo, ez);
      run_vec($sformatf("rand%0d_%02h_%02h", i, d, v), d, v, eq, eo, ez);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_signed_divider.md
Name: fixed_point_signed_divider

Overview:
- Sequential signed fixed-point divider using restoring long division, one quotient bit per clock.
- Computes quotient = dividend / divisor, both operands and result in two's-complement Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS format.
- Used as a shared arithmetic unit in the DSP filter datapath, with a start/valid handshake.

Parameters:
- DATA_WIDTH, 8, width of dividend, divisor and quotient (signed).
- FRAC_BITS, 4, number of fractional bits in all three operands (default format Q4.4).

Ports:
- i_clk  input  1  rising-edge clock.
- i_reset  input  1  asynchronous active-high reset.
- i_start  input  1  one-cycle request; operands are sampled when high in IDLE.
- i_data  input  DATA_WIDTH  signed dividend.
- i_divisor  input  DATA_WIDTH  signed divisor.
- o_data  output  DATA_WIDTH  signed quotient, registered, held until the next result.
- o_valid  output  1  one-cycle pulse when o_data updates.
- o_busy  output  1  high while a division is in progress (not IDLE).
- o_overflow  output  1  result saturated; valid with o_valid, held with o_data.
- o_div_by_zero  output  1  divisor was zero; valid with o_valid, held with o_data.

Behaviour:
- Reset (asynchronous, i_reset=1): state=IDLE. o_data, o_valid, o_busy, o_overflow and o_div_by_zero are all 0. Internal registers are cleared.
- Reset mid-operation aborts the division; no o_valid is produced.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - On i_start=1, latch sign = msb(i_data) XOR msb(i_divisor).
  - Latch a = |i_data| and b = |i_divisor| as DATA_WIDTH-bit unsigned values; -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1) without error.
  - Latch the dividend sign and a divisor-zero flag.
  - Load numerator N = a << FRAC_BITS (DATA_WIDTH+FRAC_BITS bits). Clear the remainder (DATA_WIDTH+1 bits) and the quotient magnitude q (DATA_WIDTH+FRAC_BITS bits). Go to CALC.
- CALC: runs exactly DATA_WIDTH+FRAC_BITS cycles, MSB first. Each cycle:
  - R = {R, next N bit}.
  - If R >= b: R = R - b and shift in q bit 1; otherwise shift in 0.
  - After the last iteration go to DONE.
  - With b=0 the iterations still run; the result is overridden in DONE, so latency is fixed.
- DONE (single cycle): register the result, pulse o_valid=1 for one cycle, return to IDLE.
  - Divisor zero: o_data = 2^(DATA_WIDTH-1)-1 if dividend >= 0, else -2^(DATA_WIDTH-1). o_div_by_zero=1, o_overflow=0.
  - Else, positive result: if q > 2^(DATA_WIDTH-1)-1, saturate to 0x7F (default width) with o_overflow=1; else o_data = q.
  - Else, negative result: if q > 2^(DATA_WIDTH-1), saturate to 0x80 with o_overflow=1; else o_data = -q.
  - A zero quotient is always 0, never negative zero.
- Rounding: truncation toward zero, because rounding is applied to the magnitude; the remainder is discarded.
- Latency: i_start sampled at rising edge k gives o_valid high during the cycle after edge k+DATA_WIDTH+FRAC_BITS+1 (k+13 for defaults).
- Throughput: the next i_start is accepted in the cycle o_valid is high at the earliest.
- o_busy is high from the edge after i_start until the DONE->IDLE transition.
- i_start while o_busy=1 is ignored. Operand changes after sampling have no effect.
- o_overflow and o_div_by_zero update only at DONE.

Test Plan:
- Reset: assert i_reset asynchronously mid-CALC -> all outputs 0 immediately, no o_valid afterwards; the next request completes normally.
- Basic signs: 0x30/0x20 (3.0/2.0) -> 0x18; 0xD0/0x20 -> 0xE8; 0xD0/0xE0 -> 0x18. o_valid is a single pulse exactly 13 cycles after the start edge; flags 0.
- Truncation toward zero: 0x10/0x30 -> 0x05; 0xF0/0x30 -> 0xFB.
- Saturation and boundaries:
  - 0x70/0x01 -> 0x7F, o_overflow=1.
  - 0x80/0xFF -> 0x7F, o_overflow=1.
  - 0x80/0x10 -> 0x80, o_overflow=0.
  - 0x00/0xD0 -> 0x00.
- Divide by zero: 0x30/0x00 -> 0x7F; 0xD0/0x00 -> 0x80. Both give o_div_by_zero=1, o_overflow=0, same 13-cycle latency.
- Handshake: i_start pulsed again while busy with different operands -> ignored, first result unchanged. A back-to-back start in the o_valid cycle is accepted. A 200-vector random signed sweep matches the truncating, saturating reference model.
